// File: rtl/soft_mute.sv
// Click-free mute stage: ramps a linear gain between 0 and unity, one step per
// sample, whenever the mute request changes. Output is registered (1-cycle latency).
//
// state    | meaning
// ---------+-----------------------------------------------
// MUTED    | gain held at 0, waiting for unmute request
// FADE_IN  | gain rising one code per sample
// UNMUTED  | gain held at unity, output is input delayed
// FADE_OUT | gain falling one code per sample
module soft_mute #(
    parameter int RAMP_LOG2 = 8
) (
    input  logic        clk_48,
    input  logic        reset_n,
    input  logic        mute,
    input  logic [15:0] muteIn,
    output logic [15:0] muteOut,
    output logic        muted,
    output logic        ramping
);

    localparam int MAX_GAIN = 2 ** RAMP_LOG2;
    localparam int G_W      = RAMP_LOG2 + 1;
    localparam int PROD_W   = 17 + RAMP_LOG2;

    localparam logic [G_W-1:0] G_ZERO = '0;
    localparam logic [G_W-1:0] G_ONE  = G_W'(1);
    localparam logic [G_W-1:0] G_MAX  = G_W'(MAX_GAIN);

    typedef enum logic [1:0] {
        MUTED    = 2'd0,
        FADE_IN  = 2'd1,
        UNMUTED  = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [G_W-1:0] gain_q, gain_d;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic                     unused_prod_bits;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUTED;
            gain_q  <= G_ZERO;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Magnitude compares (>= / <=) keep g inside 0..MAX_GAIN even when a
    // reversal lands a fade at its end point instead of one step short of it.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            MUTED: begin
                if (!mute) begin
                    state_d = FADE_IN;
                    gain_d  = G_ONE;
                end else begin
                    gain_d  = G_ZERO;
                end
            end
            FADE_IN: begin
                if (mute) begin
                    state_d = FADE_OUT;
                    gain_d  = gain_q - G_ONE;
                end else if (gain_q >= G_MAX - G_ONE) begin
                    state_d = UNMUTED;
                    gain_d  = G_MAX;
                end else begin
                    gain_d  = gain_q + G_ONE;
                end
            end
            UNMUTED: begin
                if (mute) begin
                    state_d = FADE_OUT;
                    gain_d  = G_MAX - G_ONE;
                end else begin
                    gain_d  = G_MAX;
                end
            end
            FADE_OUT: begin
                if (!mute) begin
                    state_d = FADE_IN;
                    gain_d  = gain_q + G_ONE;
                end else if (gain_q <= G_ONE) begin
                    state_d = MUTED;
                    gain_d  = G_ZERO;
                end else begin
                    gain_d  = gain_q - G_ONE;
                end
            end
            default: begin
                state_d = MUTED;
                gain_d  = G_ZERO;
            end
        endcase
    end

    // Selecting bits above RAMP_LOG2 of the two's-complement product is an
    // arithmetic shift that floors toward -inf; g <= MAX_GAIN keeps it in 16 bits.
    assign sample_ext = {{(PROD_W - 16){muteIn[15]}}, muteIn};
    assign gain_ext   = {{(PROD_W - G_W){1'b0}}, gain_q};
    assign product    = sample_ext * gain_ext;

    assign unused_prod_bits = ^{product[PROD_W-1], product[RAMP_LOG2-1:0]};

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            muteOut <= '0;
        end else begin
            muteOut <= product[RAMP_LOG2 +: 16];
        end
    end

    assign muted   = (gain_q == G_ZERO);
    assign ramping = (state_q == FADE_IN) || (state_q == FADE_OUT);

endmodule
